// File: rtl/hazard_irq_ctrl.sv
// Pipeline hazard control for the 5-stage RV32 core: operand forwarding, load-use stall,
// branch/redirect squash, a prioritised registered interrupt request and saturating event counters.
module hazard_irq_ctrl #(
    parameter int NUM_IRQ = 4,
    parameter int REG_W   = 5,
    parameter int CNT_W   = 16,
    localparam int CAUSE_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [REG_W-1:0]   rs1_id,
    input  logic [REG_W-1:0]   rs2_id,
    input  logic               rs1_used_id,
    input  logic               rs2_used_id,
    input  logic [REG_W-1:0]   rs1_ex,
    input  logic [REG_W-1:0]   rs2_ex,
    input  logic [REG_W-1:0]   rd_ex,
    input  logic               rf_en_ex,
    input  logic               rd_en_ex,
    input  logic [REG_W-1:0]   rd_mem,
    input  logic               rf_en_mem,
    input  logic               rd_en_mem,
    input  logic [REG_W-1:0]   rd_wb,
    input  logic               rf_en_wb,
    input  logic               br_take_ex,
    input  logic               epc_taken_mem,
    input  logic               mem_valid,
    input  logic               mret_mem,
    input  logic               mie,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_en,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b,
    output logic               stall_if,
    output logic               stall_id,
    output logic               flush_id,
    output logic               flush_ex,
    output logic               flush_mem,
    output logic               irq_take,
    output logic [CAUSE_W-1:0] irq_cause,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ARM   = 2'd1,
        ST_BLOCK = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_IRQ-1:0]   r_irq_pend;
    logic [CAUSE_W-1:0]   r_irq_cause;
    logic [CAUSE_W-1:0]   w_low_idx;
    logic [CNT_W-1:0]     r_stall_cnt;
    logic [CNT_W-1:0]     r_flush_cnt;
    logic                 w_mem_a, w_wb_a, w_mem_b, w_wb_b;
    logic                 w_lu, w_take, w_mem_redir, w_flush_id, w_stall;

    // MEM only forwards ALU results; a load in MEM is not yet available.
    assign w_mem_a = rf_en_mem && !rd_en_mem && (rd_mem != '0) && (rd_mem == rs1_ex);
    assign w_wb_a  = rf_en_wb && (rd_wb != '0) && (rd_wb == rs1_ex);
    assign w_mem_b = rf_en_mem && !rd_en_mem && (rd_mem != '0) && (rd_mem == rs2_ex);
    assign w_wb_b  = rf_en_wb && (rd_wb != '0) && (rd_wb == rs2_ex);
    assign fwd_a   = w_mem_a ? 2'b01 : (w_wb_a ? 2'b10 : 2'b00);
    assign fwd_b   = w_mem_b ? 2'b01 : (w_wb_b ? 2'b10 : 2'b00);

    assign w_lu = rd_en_ex && rf_en_ex && (rd_ex != '0) &&
                  ((rs1_used_id && (rs1_id == rd_ex)) || (rs2_used_id && (rs2_id == rd_ex)));

    assign w_mem_redir = epc_taken_mem || w_take;
    assign w_flush_id  = w_mem_redir || br_take_ex;
    assign w_stall     = w_lu && !w_flush_id;
    assign flush_id    = w_flush_id;
    assign flush_ex    = w_flush_id || w_lu;
    assign flush_mem   = w_mem_redir;
    assign stall_if    = w_stall;
    assign stall_id    = w_stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:   if (mie && (r_irq_pend != '0)) w_state_nxt = ST_ARM;
            ST_ARM:   if (w_take) w_state_nxt = ST_BLOCK;
                      else if (r_irq_pend == '0) w_state_nxt = ST_RUN;
            ST_BLOCK: if (mret_mem) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // Gated by rst so a reset landing in ARM never issues a take in that cycle.
    always_comb begin
        w_take = 1'b0;
        if (r_state == ST_ARM) w_take = rst && mem_valid && !epc_taken_mem;
    end
    assign irq_take  = w_take;
    assign state_dbg = r_state;

    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (r_irq_pend[i]) w_low_idx = CAUSE_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_irq_pend  <= '0;
            r_irq_cause <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_irq_pend <= irq & irq_en;
            if ((r_state == ST_RUN) && (w_state_nxt == ST_ARM)) r_irq_cause <= w_low_idx;
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if ((w_flush_id || w_lu) && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign irq_cause = r_irq_cause;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: doc/hazard_irq_ctrl.md
# hazard_irq_ctrl

Parametrised pipeline-control block for the 5-stage RV32 core: it resolves RAW data hazards by forwarding and load-use stalls, and squashes wrong-path instructions on EX branches and MEM redirects. It also turns a vector of `NUM_IRQ` level interrupt lines into a single registered, prioritised trap request for the MEM-stage CSR unit. Saturating stall and flush event counters are included. The block sits beside the stage buffers and drives their stall/flush inputs and the EX operand-mux forwarding selects.

## Interface
- `NUM_IRQ`, 4: number of interrupt lines (1..32).
- `REG_W`, 5: register-index width.
- `CNT_W`, 16: width of the performance counters.
- `clk` in 1: clock.
- `rst` in 1: reset, **synchronous, active-low**. `rst=0` at a rising `clk` edge resets the block.
- `rs1_id`, `rs2_id` in `REG_W`: source indices of the instruction in ID.
- `rs1_used_id`, `rs2_used_id` in 1: those sources are actually read.
- `rs1_ex`, `rs2_ex` in `REG_W`: source indices of the instruction in EX.
- `rd_ex`, `rf_en_ex`, `rd_en_ex` in `REG_W`/1/1: destination of EX, its write-enable, and load flag.
- `rd_mem`, `rf_en_mem`, `rd_en_mem` in `REG_W`/1/1: same fields for MEM.
- `rd_wb`, `rf_en_wb` in `REG_W`/1: same fields for WB.
- `br_take_ex` in 1: branch/jump taken, resolved in EX.
- `epc_taken_mem` in 1: CSR redirect (trap/mret) from MEM.
- `mem_valid` in 1: MEM holds a real, non-bubble instruction.
- `mret_mem` in 1: mret is in MEM.
- `mie` in 1: global interrupt enable.
- `irq` in `NUM_IRQ`: level interrupt lines.
- `irq_en` in `NUM_IRQ`: per-line enables.
- `fwd_a`, `fwd_b` out 2: operand select. 00 = regfile, 01 = MEM ALU result, 10 = WB data.
- `stall_if`, `stall_id` out 1: hold the PC and the IF/ID buffer.
- `flush_id`, `flush_ex`, `flush_mem` out 1: load a bubble into the IF/ID, ID/EX and EX/MEM buffers respectively.
- `irq_take` out 1: trap request to the CSR unit.
- `irq_cause` out `$clog2(NUM_IRQ)` (min 1): index of the line being taken.
- `stall_cnt`, `flush_cnt` out `CNT_W`: event counters.

## Operation
**Forwarding (combinational)**
- `fwd_a = 01` if `rf_en_mem && !rd_en_mem && rd_mem!=0 && rd_mem==rs1_ex`.
- Otherwise `fwd_a = 10` if `rf_en_wb && rd_wb!=0 && rd_wb==rs1_ex`.
- Otherwise `fwd_a = 00`.
- `fwd_b` follows the same rules with `rs2_ex`. MEM takes priority over WB.

**Load-use detection**
- `lu = rd_en_ex && rf_en_ex && rd_ex!=0 && ((rs1_used_id && rs1_id==rd_ex) || (rs2_used_id && rs2_id==rd_ex))`.

**Redirect/stall priority, highest first**
1. MEM redirect: `epc_taken_mem` or `irq_take`. Assert `flush_id`, `flush_ex`, `flush_mem`; no stall.
2. `br_take_ex`: assert `flush_id` and `flush_ex`.
3. `lu`: assert `stall_if`, `stall_id`, `flush_ex`. This inserts exactly one bubble.

**Interrupt path**
- `irq_pend` register: `irq_pend <= irq & irq_en` every cycle.
- State machine, three states:
  - RUN: if `mie && |irq_pend`, latch `irq_cause` = lowest set index of `irq_pend` and go to ARM.
  - ARM: `irq_take = mem_valid && !epc_taken_mem`. If `irq_take`, go to BLOCK. Else if `irq_pend==0`, return to RUN (cancelled, no take).
  - BLOCK: no new requests. On `mret_mem`, go to RUN.
- `irq_take` is asserted only in ARM.

**Counters**
- `stall_cnt` increments on each cycle with `lu` asserted and not overridden by a higher-priority event.
- `flush_cnt` increments on each cycle with any `flush_*` asserted.
- Both saturate at all-ones and do not wrap.

## Timing
- Reset state: RUN, `irq_pend=0`, `irq_cause=0`, both counters 0.
- With idle inputs (all enables 0) after reset, every output is 0.
- Forwarding, stall and flush outputs are combinational, with zero latency from their inputs.
- Interrupt latency: `irq` sampled high at edge k gives `irq_pend` at k, state ARM at k+1, and the earliest `irq_take` in the cycle after k+1. `irq_take` lasts exactly one cycle per interrupt.
- `irq_cause` is stable from ARM entry until the next RUN→ARM transition.
- Simultaneous events:
  - `br_take_ex` together with `irq_take`: MEM flush set wins.
  - `lu` together with `br_take_ex`: no stall; `flush_ex` stays asserted.
  - `epc_taken_mem` in ARM: the take is deferred to the next cycle.
- Reset asserted mid-ARM or mid-BLOCK: state returns to RUN at that edge, and no `irq_take` occurs in the reset cycle.
- `rd=0` never forwards and never stalls.

## Test plan
- **Forwarding:** `rf_en_mem=1, rd_mem=5, rs1_ex=5, rf_en_wb=1, rd_wb=5` -> `fwd_a=01`. Then with `rf_en_mem=0` -> `fwd_a=10`. With `rd_mem=rd_wb=0` -> `fwd_a=00`.
- **Load-use:** `rd_en_ex=1, rf_en_ex=1, rd_ex=7, rs2_id=7, rs2_used_id=1` -> `stall_if=stall_id=flush_ex=1` for one cycle, `stall_cnt` 0->1. Repeat with `rs2_used_id=0` -> no stall.
- **Branch vs load-use:** `br_take_ex=1` with `lu` true -> `flush_id=flush_ex=1`, `stall_*=0`, `flush_cnt` +1, `stall_cnt` unchanged.
- **Interrupt priority:** `mie=1, irq_en=4'b1111`, `irq=4'b1010` from edge 0, `mem_valid=1` -> `irq_take=1` exactly in cycle 2 with `irq_cause=1` and all three flushes set. No further take until a `mret_mem` pulse, and a take resumes 2 cycles after it.
- **Deferral and cancel:** in ARM with `mem_valid=0` for 3 cycles, no take, then a take on the first cycle `mem_valid=1`. Separately, drop `irq` while in ARM -> state returns to RUN with no `irq_take`.
- **Saturation and reset:** with `CNT_W=4`, 20 consecutive flushes -> `flush_cnt=15`. Assert `rst=0` while in ARM -> next cycle RUN, counters 0, `irq_take=0`.
